// File: rtl/lc3b_regfile_pkg.sv
// Shared LC-3b datapath constants and types for the operand-supply stage.
// Condition codes travel as a packed {n,z,p} struct so the reset encoding reads naturally.
package lc3b_regfile_pkg;

  localparam int LC3B_DATA_W   = 16;
  localparam int LC3B_NUM_REGS = 8;
  localparam int LC3B_IDX_W    = 3;
  localparam int LC3B_IMM5_W   = 5;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = 3'b010;

  typedef enum logic {
    SR2MUX_REG = 1'b0,
    SR2MUX_IMM = 1'b1
  } sr2mux_sel_e;

endpackage

// File: rtl/lc3b_regfile_if.sv
// Control, bus and operand signals between the LC-3b control unit and the register file.
// The control unit is the master; the register file is the slave.
interface lc3b_regfile_if;
  import lc3b_regfile_pkg::*;

  logic                   ld_reg;
  logic [LC3B_IDX_W-1:0]  dr;
  logic [LC3B_DATA_W-1:0] bus_in;
  logic [LC3B_IDX_W-1:0]  sr1;
  logic [LC3B_IDX_W-1:0]  sr2;
  logic                   sr2mux_sel;
  logic [LC3B_IMM5_W-1:0] imm5;
  logic                   ld_cc;
  logic [LC3B_DATA_W-1:0] a;
  logic [LC3B_DATA_W-1:0] b;
  logic                   n;
  logic                   z;
  logic                   p;

  modport master (
    output ld_reg, dr, bus_in, sr1, sr2, sr2mux_sel, imm5, ld_cc,
    input  a, b, n, z, p
  );

  modport slave (
    input  ld_reg, dr, bus_in, sr1, sr2, sr2mux_sel, imm5, ld_cc,
    output a, b, n, z, p
  );

endinterface

// File: rtl/lc3b_regfile_nzp_gen.sv
// Combinational value-to-{n,z,p} classifier; shared with the load/store path.
module lc3b_nzp_gen
  import lc3b_regfile_pkg::*;
#(
  parameter int DATA_W = LC3B_DATA_W
) (
  input  logic [DATA_W-1:0] value_i,
  output cc_t               cc_o
);

  logic is_zero;

  assign is_zero = (value_i == '0);

  assign cc_o.n = value_i[DATA_W-1];
  assign cc_o.z = is_zero;
  assign cc_o.p = ~value_i[DATA_W-1] & ~is_zero;

endmodule

// File: rtl/lc3b_regfile.sv
// LC-3b general register file with NZP condition codes, feeding ALU operands A and B.
// Reads are combinational; BYPASS forwards a same-cycle write-back onto the read ports.
module lc3b_regfile
  import lc3b_regfile_pkg::*;
#(
  parameter int NUM_REGS = LC3B_NUM_REGS,
  parameter int DATA_W   = LC3B_DATA_W,
  parameter bit BYPASS   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  lc3b_regfile_if.slave  rf
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  cc_t               cc_q;
  cc_t               cc_d;
  cc_t               bus_cc;

  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] imm_sext;
  logic              hit_sr1;
  logic              hit_sr2;

  lc3b_nzp_gen #(.DATA_W(DATA_W)) u_nzp_gen (
    .value_i (rf.bus_in),
    .cc_o    (bus_cc)
  );

  // NOTE: the array is reset explicitly because R0-R7 must read zero after reset;
  // this costs a flop reset per bit, so storage without that requirement would skip it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf.ld_reg) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      regs_q[rf.dr] <= rf.bus_in;
    end
  end

  always_comb begin
    cc_d = cc_q;
    if (rf.ld_cc) begin
      cc_d = bus_cc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign hit_sr1  = BYPASS && rf.ld_reg && (rf.dr == rf.sr1);
  assign hit_sr2  = BYPASS && rf.ld_reg && (rf.dr == rf.sr2);
  assign imm_sext = {{(DATA_W-LC3B_IMM5_W){rf.imm5[LC3B_IMM5_W-1]}}, rf.imm5};

  // NOTE: each output is assigned a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_d   = regs_q[rf.sr1];
    b_reg = regs_q[rf.sr2];
    if (hit_sr1) begin
      a_d = rf.bus_in;
    end
    if (hit_sr2) begin
      b_reg = rf.bus_in;
    end
  end

  // The immediate leg sits after the bypass mux, so it is never forwarded.
  assign rf.a = a_d;
  assign rf.b = (rf.sr2mux_sel == SR2MUX_IMM) ? imm_sext : b_reg;
  assign rf.n = cc_q.n;
  assign rf.z = cc_q.z;
  assign rf.p = cc_q.p;

endmodule
